// File: rtl/mxv_result_serializer.sv
// Serializes packed matrix-by-vector result words into one element per handshake.
// Define MXV_RESULT_OVERFLOW_STICKY_EN to hold overflow until start/reset instead of pulsing.
module mxv_result_serializer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int fifo_depth    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total_rows,
  input  logic                                 read_now,
  input  logic [no_of_units*element_width-1:0] mxv_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [element_width-1:0]             out_data,
  output logic [31:0]                          out_index,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [$clog2(fifo_depth):0]          fifo_level
);

  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int LW = $clog2(fifo_depth) + 1;
  localparam int EW = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam int WW = no_of_units * element_width;
  localparam logic [LW-1:0] FULL_LVL  = LW'(fifo_depth);
  localparam logic [AW-1:0] LAST_SLOT = AW'(fifo_depth - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(no_of_units - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [WW-1:0] mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [EW-1:0] elem_ptr;
  logic [31:0]   total_q;
  logic [WW-1:0] head;
  logic          full, handshake, last_elem, last_row, pop, push, drop;

  assign full      = (count == FULL_LVL);
  assign out_valid = (state == RUN) && (count != '0);
  assign handshake = out_valid && out_ready;
  assign last_elem = (elem_ptr == LAST_ELEM);
  assign last_row  = handshake && (out_index == total_q - 32'd1);
  assign pop       = handshake && last_elem;
  // A full FIFO still accepts a word when the head word leaves on the same edge.
  assign push      = (state == RUN) && !start && read_now && (!full || pop);
  assign drop      = (state == RUN) && !start && read_now && full && !pop;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fifo_level = count;
  assign head      = mem[rd_ptr];

  // Element 0 sits in the most significant slice of the word.
  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < no_of_units; j++) begin
      if (out_valid && elem_ptr == EW'(j))
        out_data = head[(no_of_units-1-j)*element_width +: element_width];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start)
      state_next = (total_rows == '0) ? DONE : RUN;
    else if (state == RUN && last_row)
      state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mxv_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      elem_ptr  <= '0;
      out_index <= '0;
      total_q   <= '0;
      overflow  <= 1'b0;
    end else if (start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      elem_ptr  <= '0;
      out_index <= '0;
      total_q   <= total_rows;
      overflow  <= 1'b0;
    end else begin
`ifdef MXV_RESULT_OVERFLOW_STICKY_EN
      if (drop) overflow <= 1'b1;
`else
      overflow <= drop;
`endif
      if (handshake) out_index <= out_index + 32'd1;
      if (last_row) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        elem_ptr <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
        if (handshake) elem_ptr <= last_elem ? '0 : elem_ptr + 1'b1;
        count <= count + LW'(push) - LW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_mxv_result_serializer.sv
// Directed bench for mxv_result_serializer with default parameters.
module tb_mxv_result_serializer;

  localparam int EW = 32;
  localparam int NU = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [31:0]    total_rows;
  logic           read_now;
  logic [NU*EW-1:0] mxv_result;
  logic           out_valid;
  logic           out_ready;
  logic [EW-1:0]  out_data;
  logic [31:0]    out_index;
  logic           busy, done, overflow;
  logic [2:0]     fifo_level;

  int vectors = 0;
  int miscompares = 0;
  int stall_err;
  logic [31:0] obs_d[$];
  logic [31:0] obs_i[$];
  logic [31:0] exp_q[$];

  mxv_result_serializer #(.element_width(EW), .no_of_units(NU), .fifo_depth(4)) dut (
    .clk(clk), .reset(reset), .start(start), .total_rows(total_rows),
    .read_now(read_now), .mxv_result(mxv_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NU*EW-1:0] mk(input int base);
    logic [NU*EW-1:0] w;
    w = '0;
    for (int j = 0; j < NU; j++) w[(NU-1-j)*EW +: EW] = 32'(base + j);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rows);
    start = 1'b1;
    total_rows = 32'(rows);
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input int base);
    read_now = 1'b1;
    mxv_result = mk(base);
    tick();
    read_now = 1'b0;
  endtask

  // Gathers handshaken elements; optionally pushes one word on the handshake of index push_at.
  task automatic collect(input int n, input bit tog, input int push_at, input int pbase, output int got);
    bit prev_st;
    logic [31:0] pd, pi;
    got = 0;
    prev_st = 1'b0;
    pd = '0;
    pi = '0;
    stall_err = 0;
    obs_d.delete();
    obs_i.delete();
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      out_ready = tog ? cyc[0] : 1'b1;
      read_now = (push_at >= 0) && out_valid && out_ready && (out_index == 32'(push_at));
      mxv_result = mk(pbase);
      #4;
      if (prev_st && (!out_valid || out_data !== pd || out_index !== pi)) stall_err++;
      prev_st = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data);
        obs_i.push_back(out_index);
        got++;
      end
      @(posedge clk);
      #1;
    end
    read_now = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, busy, done, overflow} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, done, overflow});
    end
    vectors++;
    if (out_data !== '0 || out_index !== '0 || fifo_level !== '0) begin
      miscompares++;
      $display("FAIL reset_values: data=%0h idx=%0d lvl=%0d want 0/0/0", out_data, out_index, fifo_level);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_16();
    int got;
    out_ready = 1'b0;
    do_start(16);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL full16_busy: got %b want 1", busy);
    end
    push_word(100);
    push_word(200);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(100 + k));
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(200 + k));
    collect(16, 1'b0, -1, 0, got);
    vectors++;
    if (got !== 16) begin
      miscompares++;
      $display("FAIL full16_count: got %0d want 16", got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (obs_d[i] !== exp_q[i] || obs_i[i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL full16_elem%0d: data=%0d idx=%0d want %0d/%0d", i, obs_d[i], obs_i[i], exp_q[i], i);
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full16_done: done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_truncate_10();
    int got;
    out_ready = 1'b0;
    do_start(10);
    push_word(300);
    push_word(400);
    collect(10, 1'b0, -1, 0, got);
    vectors++;
    if (got !== 10) begin
      miscompares++;
      $display("FAIL trunc_count: got %0d want 10", got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (obs_d[i] !== 32'(i < 8 ? 300 + i : 400 + i - 8) || obs_i[i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL trunc_elem%0d: data=%0d idx=%0d", i, obs_d[i], obs_i[i]);
      end
    end
    repeat (3) begin
      vectors++;
      if (done !== 1'b1 || out_valid !== 1'b0 || fifo_level !== 3'd0) begin
        miscompares++;
        $display("FAIL trunc_done: done=%b valid=%b lvl=%0d want 1/0/0", done, out_valid, fifo_level);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    int got;
    out_ready = 1'b0;
    do_start(40);
    push_word(500);
    push_word(600);
    push_word(700);
    push_word(800);
    push_word(900);
    vectors++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: lvl=%0d ovf=%b want 4/1", fifo_level, overflow);
    end
    tick();
    vectors++;
`ifdef MXV_RESULT_OVERFLOW_STICKY_EN
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_after: got %b want 1", overflow);
    end
`else
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_after: got %b want 0", overflow);
    end
`endif
    // Word 950 arrives exactly as the full FIFO retires its head word.
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(500 + k));
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(600 + k));
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(700 + k));
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(800 + k));
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(950 + k));
    collect(40, 1'b0, 7, 950, got);
    vectors++;
    if (got !== 40) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d want 40", got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (obs_d[i] !== exp_q[i] || obs_i[i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL ovf_elem%0d: data=%0d idx=%0d want %0d/%0d", i, obs_d[i], obs_i[i], exp_q[i], i);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_done: got %b want 1", done);
    end
  endtask

  task automatic test_stall_toggle();
    int got;
    out_ready = 1'b0;
    do_start(16);
    push_word(1000);
    push_word(1100);
    collect(16, 1'b1, -1, 0, got);
    vectors++;
    if (got !== 16 || stall_err !== 0) begin
      miscompares++;
      $display("FAIL stall_summary: got %0d elems, %0d unstable, want 16/0", got, stall_err);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (obs_d[i] !== 32'(i < 8 ? 1000 + i : 1100 + i - 8) || obs_i[i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL stall_elem%0d: data=%0d idx=%0d", i, obs_d[i], obs_i[i]);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_done: got %b want 1", done);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    out_ready = 1'b0;
    do_start(16);
    push_word(1200);
    push_word(1300);
    collect(5, 1'b0, -1, 0, got);
    vectors++;
    if (got !== 5 || out_valid !== 1'b1 || out_index !== 32'd5 || out_data !== 32'd1205) begin
      miscompares++;
      $display("FAIL mid_pre: got=%0d valid=%b idx=%0d data=%0d want 5/1/5/1205", got, out_valid, out_index, out_data);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, done, overflow} !== 4'b0 || out_data !== '0 || out_index !== '0 || fifo_level !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b ovf=%b data=%0d idx=%0d lvl=%0d want all 0",
               out_valid, busy, done, overflow, out_data, out_index, fifo_level);
    end
    tick();
    reset = 1'b1;
    tick();
    push_word(1400);
    vectors++;
    if (fifo_level !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_idle_ignore: lvl=%0d busy=%b valid=%b want 0/0/0", fifo_level, busy, out_valid);
    end
    out_ready = 1'b0;
    do_start(8);
    push_word(1500);
    collect(8, 1'b0, -1, 0, got);
    vectors++;
    if (got !== 8 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_restart: got %0d done=%b want 8/1", got, done);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (obs_d[i] !== 32'(1500 + i) || obs_i[i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL mid_elem%0d: data=%0d idx=%0d want %0d/%0d", i, obs_d[i], obs_i[i], 1500 + i, i);
      end
    end
  endtask

  task automatic test_zero_rows();
    out_ready = 1'b1;
    do_start(0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy);
    end
    read_now = 1'b1;
    mxv_result = mk(1600);
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_ignore%0d: valid=%b lvl=%0d ovf=%b want 0/0/0", c, out_valid, fifo_level, overflow);
      end
    end
    read_now = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    total_rows = '0;
    read_now = 1'b0;
    mxv_result = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_16();
    test_truncate_10();
    test_overflow();
    test_stall_toggle();
    test_reset_mid();
    test_zero_rows();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
